// File: rtl/tp_pkg.sv
// rtl/tp_pkg.sv - shared constants, state encoding and byte-swap helper for the test-port capture block
package tp_pkg;

    localparam logic [29:0] TEST_PORT    = 30'h3FF;
    localparam logic [31:0] BEGIN_SYMBOL = 32'h00000168;
    localparam logic [31:0] END_SYMBOL   = 32'hFFFFFD5D;

    localparam int INDEX_W = 10;
    localparam int ENTRY_W = 32 + INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // D-side bus is little-endian; symbols and captured words are compared big-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/tp_write_capture_if.sv
// rtl/tp_write_capture_if.sv - D-side write snoop, captured-word stream and status bundle
interface tp_write_capture_if;

    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [9:0]  out_index;
    logic        armed;
    logic        done;
    logic [15:0] duration;
    logic        overflow;
    logic [7:0]  drop_count;

    modport master (
        output addr, data, wen, out_ready,
        input  out_valid, out_data, out_index, armed, done, duration, overflow, drop_count
    );

    modport slave (
        input  addr, data, wen, out_ready,
        output out_valid, out_data, out_index, armed, done, duration, overflow, drop_count
    );

endinterface

// File: rtl/tp_fifo.sv
// rtl/tp_fifo.sv - first-word-fall-through capture buffer; accepts a push into a full buffer when a pop happens the same cycle
module tp_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 42
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign valid_o    = (count_q != '0);
    assign full_o     = (count_q == FULL_CNT);
    assign do_pop     = pop_i && valid_o;
    assign do_push    = push_i && (!full_o || do_pop);
    // Head is masked when empty so the stream reads zero after reset.
    assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tp_write_capture.sv
// rtl/tp_write_capture.sv - snoops D-side writes to the test port and streams the words framed by begin/end symbols
module tp_write_capture #(
    parameter logic [29:0] TEST_PORT    = tp_pkg::TEST_PORT,
    parameter logic [31:0] BEGIN_SYMBOL = tp_pkg::BEGIN_SYMBOL,
    parameter logic [31:0] END_SYMBOL   = tp_pkg::END_SYMBOL,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic clk,
    input  logic rst,
    tp_write_capture_if.slave bus
);

    import tp_pkg::*;

    state_e              state_q;
    logic                armed_q;
    logic                done_q;
    logic                wen_q;
    logic [INDEX_W-1:0]  index_q,    index_d;
    logic [15:0]         duration_q, duration_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_q,     drop_d;

    logic [31:0]         swapped;
    logic                event_w;
    logic                push_req;
    logic                pop;
    logic                drop;
    logic                fifo_valid;
    logic                fifo_full;
    logic [ENTRY_W-1:0]  fifo_dout;

    assign swapped  = bswap32(bus.data);
    // Edge-detect on wen so a stalled store held for many cycles counts once.
    assign event_w  = bus.wen && !wen_q && (bus.addr == TEST_PORT);
    assign push_req = event_w && (state_q == ST_ARMED);
    assign pop      = fifo_valid && bus.out_ready;
    assign drop     = push_req && fifo_full && !pop;

    tp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_req),
        .push_data_i ({swapped, index_q}),
        .pop_i       (bus.out_ready),
        .pop_data_o  (fifo_dout),
        .valid_o     (fifo_valid),
        .full_o      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (event_w && swapped == BEGIN_SYMBOL) begin
                        state_q <= ST_ARMED;
                        armed_q <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    // Terminates even when the end word itself is dropped.
                    if (push_req && swapped == END_SYMBOL) begin
                        state_q <= ST_DONE;
                        armed_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    always_comb begin
        index_d    = index_q;
        duration_d = duration_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (push_req) begin
            index_d = index_q + 1'b1;
        end
        if (state_q == ST_ARMED && duration_q != 16'hFFFF) begin
            duration_d = duration_q + 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q      <= 1'b0;
            index_q    <= '0;
            duration_q <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wen_q      <= bus.wen;
            index_q    <= index_d;
            duration_q <= duration_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.out_valid  = fifo_valid;
    assign bus.out_data   = fifo_dout[ENTRY_W-1:INDEX_W];
    assign bus.out_index  = fifo_dout[INDEX_W-1:0];
    assign bus.armed      = armed_q;
    assign bus.done       = done_q;
    assign bus.duration   = duration_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_tp_write_capture.sv
// tb/tb_tp_write_capture.sv - scoreboard bench for tp_write_capture with directed capture sequences
module tb_tp_write_capture;

    import tp_pkg::*;

    localparam logic [31:0] BEG = 32'h00000168;
    localparam logic [31:0] EOS = 32'hFFFFFD5D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [41:0] exp_q [$];

    tp_write_capture_if bus();

    tp_write_capture #(
        .TEST_PORT    (30'h3FF),
        .BEGIN_SYMBOL (32'h00000168),
        .END_SYMBOL   (32'hFFFFFD5D),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [9:0] idx);
        exp_q.push_back({d, idx});
    endtask

    // Called and returns at posedge+1; event edge is the first posedge after wen rises.
    task automatic wr(input logic [29:0] a, input logic [31:0] v, input int hold);
        bus.addr = a;
        bus.data = bswap32(v);
        bus.wen  = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.wen = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wen = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d words left want 0", name, exp_q.size());
            exp_q.delete();
        end
        chk({name, "_valid_after_drain"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Monitor: a handshake seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got data=%0h idx=%0d want none", bus.out_data, bus.out_index);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                if ({bus.out_data, bus.out_index} !== e) begin
                    bad++;
                    $display("FAIL stream_word: got data=%0h idx=%0d want data=%0h idx=%0d",
                             bus.out_data, bus.out_index, e[41:10], e[9:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr = '0;
        bus.data = '0;
        bus.wen = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();

        chk("rst_valid",    32'(bus.out_valid),  32'd0);
        chk("rst_armed",    32'(bus.armed),      32'd0);
        chk("rst_done",     32'(bus.done),       32'd0);
        chk("rst_data",     bus.out_data,        32'd0);
        chk("rst_index",    32'(bus.out_index),  32'd0);
        chk("rst_duration", 32'(bus.duration),   32'd0);
        chk("rst_overflow", 32'(bus.overflow),   32'd0);
        chk("rst_drops",    32'(bus.drop_count), 32'd0);

        // Basic frame with a ready consumer.
        bus.out_ready = 1'b1;
        wr(30'h3FF, BEG, 1);
        chk("basic_armed", 32'(bus.armed), 32'd1);
        expect_word(32'd5, 10'd0); wr(30'h3FF, 32'd5, 1);
        expect_word(32'd7, 10'd1); wr(30'h3FF, 32'd7, 1);
        expect_word(EOS,   10'd2); wr(30'h3FF, EOS,   1);
        drain("basic");
        chk("basic_done",     32'(bus.done),     32'd1);
        chk("basic_armed_lo", 32'(bus.armed),    32'd0);
        chk("basic_duration", 32'(bus.duration), 32'd6);

        // Events in DONE are ignored.
        wr(30'h3FF, BEG, 1);
        wr(30'h3FF, 32'd5, 1);
        drain("done_ignore");
        chk("done_stays", 32'(bus.done), 32'd1);

        // Wrong address / non-begin words do not arm; wrong address while armed is ignored.
        do_reset();
        bus.out_ready = 1'b1;
        wr(30'h100, BEG, 1);
        chk("wrong_addr_idle", 32'(bus.armed), 32'd0);
        wr(30'h3FF, 32'd5, 1);
        chk("nonbegin_idle", 32'(bus.armed), 32'd0);
        wr(30'h3FF, BEG, 1);
        chk("arm_again", 32'(bus.armed), 32'd1);
        wr(30'h3FE, 32'd3, 1);
        chk("wrong_addr_armed", 32'(bus.armed), 32'd1);

        // Held wen yields one event; begin symbol in ARMED is data.
        expect_word(32'd9,  10'd0); wr(30'h3FF, 32'd9, 4);
        expect_word(32'd11, 10'd1); wr(30'h3FF, 32'd11, 1);
        expect_word(BEG,    10'd2); wr(30'h3FF, BEG, 1);
        expect_word(EOS,    10'd3); wr(30'h3FF, EOS, 1);
        drain("held_wen");
        chk("held_done", 32'(bus.done), 32'd1);

        // Overflow with a stalled consumer, then push concurrent with pop on a full buffer.
        do_reset();
        bus.out_ready = 1'b0;
        wr(30'h3FF, BEG, 1);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) expect_word(32'd100 + 32'(i), 10'(i));
            wr(30'h3FF, 32'd100 + 32'(i), 1);
        end
        chk("ovf_flag",  32'(bus.overflow),   32'd1);
        chk("ovf_drops", 32'(bus.drop_count), 32'd2);
        chk("ovf_valid", 32'(bus.out_valid),  32'd1);
        chk("ovf_hold_data",  bus.out_data,          32'd100);
        chk("ovf_hold_index", 32'(bus.out_index),    32'd0);
        bus.out_ready = 1'b1;
        expect_word(32'd200, 10'd10); wr(30'h3FF, 32'd200, 1);
        chk("pushpop_drops", 32'(bus.drop_count), 32'd2);
        expect_word(EOS, 10'd11); wr(30'h3FF, EOS, 1);
        drain("overflow");
        chk("ovf_final_drops", 32'(bus.drop_count), 32'd2);

        // Dropped end symbol still terminates the capture.
        do_reset();
        bus.out_ready = 1'b0;
        wr(30'h3FF, BEG, 1);
        for (int i = 0; i < 8; i++) begin
            expect_word(32'd1 + 32'(i), 10'(i));
            wr(30'h3FF, 32'd1 + 32'(i), 1);
        end
        wr(30'h3FF, EOS, 1);
        chk("drop_end_done",  32'(bus.done),       32'd1);
        chk("drop_end_armed", 32'(bus.armed),      32'd0);
        chk("drop_end_drops", 32'(bus.drop_count), 32'd1);
        drain("drop_end");

        // Reset mid-capture discards buffered words; fresh capture restarts at index 0.
        do_reset();
        bus.out_ready = 1'b0;
        wr(30'h3FF, BEG, 1);
        wr(30'h3FF, 32'd21, 1);
        wr(30'h3FF, 32'd22, 1);
        wr(30'h3FF, 32'd23, 1);
        chk("mid_valid_before", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_valid_after",    32'(bus.out_valid), 32'd0);
        chk("mid_armed_after",    32'(bus.armed),     32'd0);
        chk("mid_duration_after", 32'(bus.duration),  32'd0);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wr(30'h3FF, BEG, 1);
        expect_word(32'h55, 10'd0); wr(30'h3FF, 32'h55, 1);
        expect_word(EOS,    10'd1); wr(30'h3FF, EOS, 1);
        drain("rearm");
        chk("rearm_done", 32'(bus.done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
